// File: rtl/uart_rx_if.sv
// Byte-out side of uart_rx: valid/ready byte handshake plus one-cycle error pulses.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        input  overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// 2-of-3 mid-bit majority voting, held-byte handshake with overrun detection.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic      clk,
    input  logic      n_reset,
    input  logic      uart_rx_pin,
    uart_rx_if.master rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP0 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SMP1 = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] DEC  = CW'(CLKS_PER_BIT / 2 + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [1:0]    warm_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          pbad_q, pbad_d;
`endif

    logic          rx_s;
    logic          maj;
    logic          dec;
    logic          done;
    logic          hs;
    logic [CW-1:0] cnt_inc;

    assign rx_s    = sync_q[1];
    assign dec     = (cnt_q == DEC);
    assign cnt_inc = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    assign maj     = (smp_q[0] & smp_q[1]) |
                     (smp_q[0] & rx_s) |
                     (smp_q[1] & rx_s);
    assign hs      = valid_q & rx.rx_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif

        if (state_q != WAIT_IDLE && state_q != IDLE) begin
            cnt_d = cnt_inc;
            if (cnt_q == SMP0) smp_d[0] = rx_s;
            if (cnt_q == SMP1) smp_d[1] = rx_s;
        end

        unique case (state_q)
            WAIT_IDLE: begin
                cnt_d = '0;
                // synchroniser holds reset value until refilled from the pin
                if (warm_q[1] && rx_s) state_d = IDLE;
            end
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    pbad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (dec) state_d = maj ? IDLE : DATA;
            end
            DATA: begin
                if (dec) begin
                    shreg_d = {maj, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (dec) begin
                    if (maj != ^shreg_q) begin
                        perr_d = 1'b1;
                        pbad_d = 1'b1;
                    end
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (dec) begin
                    if (maj) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        done    = ~pbad_q;
`else
                        done    = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (done) begin
            // a byte taken this cycle frees the slot for the new one
            if (!valid_q || hs) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= WAIT_IDLE;
            sync_q  <= 2'b11;
            warm_q  <= 2'b00;
            cnt_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shreg_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], uart_rx_pin};
            warm_q  <= {warm_q[0], 1'b1};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            perr_q <= 1'b0;
            pbad_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
            pbad_q <= pbad_d;
        end
    end

    assign rx.parity_err = perr_q;
`else
    assign rx.parity_err = 1'b0;
`endif

    assign rx.rx_data     = data_q;
    assign rx.rx_valid    = valid_q;
    assign rx.frame_err   = ferr_q;
    assign rx.overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clks/bit: stimulus pushes expected
// events with their cycle stamps, a negedge monitor pops and compares.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif

    typedef enum int {EV_NONE, EV_BYTE, EV_FERR, EV_PERR, EV_OVR} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic uart_rx_pin = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .uart_rx_pin (uart_rx_pin),
        .rx          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_evt(input ev_t kind, input logic [7:0] d);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL evt: got %s data=%02h cyc=%0d, required none",
                     kind.name(), d, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_BYTE && e.data != d)) begin
                failures++;
                $display("FAIL evt: got %s data=%02h cyc=%0d, required %s data=%02h cyc=%0d",
                         kind.name(), d, cyc, e.kind.name(), e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!n_reset) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (bus.frame_err)   chk_evt(EV_FERR, 8'h00);
            if (bus.overrun_err) chk_evt(EV_OVR, 8'h00);
            if (bus.parity_err)  chk_evt(EV_PERR, 8'h00);
            if (bus.rx_valid && (!prev_v || prev_hs))
                chk_evt(EV_BYTE, bus.rx_data);
            prev_v  = bus.rx_valid;
            prev_hs = bus.rx_valid && bus.rx_ready;
        end
    end

    task automatic hold(input logic lvl, input int n);
        uart_rx_pin = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns after an edge k; every frame event lands at edge k+13+16*idx.
    task automatic send(input logic [7:0] d, input logic stop,
                        input logic pflip, input ev_t done_ev);
        logic b[$];
        int   k;
        k = cyc;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
        b.push_back((^d) ^ pflip);
        if (pflip) sbq.push_back('{EV_PERR, d, k + 13 + CPB * 9});
`endif
        b.push_back(stop);
        if (done_ev != EV_NONE)
            sbq.push_back('{done_ev, d, k + 13 + CPB * STOP_IDX});
        foreach (b[i]) hold(b[i], CPB);
    endtask

    initial begin
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 8'h00);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_perr", bus.parity_err, 0);
        check("rst_ovr", bus.overrun_err, 0);
        n_reset = 1'b1;
        hold(1'b1, 20);

        send(8'hA5, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 10);
        check("a5_pulse", bus.rx_valid, 0);

        hold(1'b0, 4);
        hold(1'b1, 30);
        send(8'hC3, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 10);

        send(8'h3C, 1'b0, 1'b0, EV_FERR);
        hold(1'b0, 32);
        hold(1'b1, 20);
        send(8'h96, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 10);

        bus.rx_ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, EV_BYTE);
        send(8'h22, 1'b1, 1'b0, EV_OVR);
        hold(1'b1, 10);
        check("ovr_valid", bus.rx_valid, 1);
        check("ovr_data", bus.rx_data, 8'h11);
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drop", bus.rx_valid, 0);

        bus.rx_ready = 1'b0;
        send(8'h44, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 5);
        fork
            send(8'h55, 1'b1, 1'b0, EV_BYTE);
            begin
                repeat (156) @(posedge clk);
                #1 bus.rx_ready = 1'b1;
                @(posedge clk);
                #1 bus.rx_ready = 1'b0;
            end
        join
        check("hs_valid", bus.rx_valid, 1);
        check("hs_data", bus.rx_data, 8'h55);

        hold(1'b0, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB / 2);
        uart_rx_pin = 1'b0;
        n_reset = 1'b0;
        #1;
        check("mid_rst_valid", bus.rx_valid, 0);
        check("mid_rst_data", bus.rx_data, 8'h00);
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        hold(1'b0, 200);
        hold(1'b1, 20);
        bus.rx_ready = 1'b1;
        send(8'h7E, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 10);

`ifdef UART_RX_PARITY_EN
        send(8'h01, 1'b1, 1'b1, EV_NONE);
        hold(1'b1, 10);
        send(8'h01, 1'b1, 1'b0, EV_BYTE);
        hold(1'b1, 10);
`endif

        hold(1'b1, 20);
        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port n_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port uart_rx_pin  input  1  raw asynchronous serial line; idle high.
REQ-005 SHALL have port rx_data  output  8  received byte; stable while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).
REQ-010 SHALL have port overrun_err  output  1  one-cycle pulse: completed byte dropped.

Function
REQ-011 SHALL pass uart_rx_pin through a 2-flop synchroniser; all decoding uses the synchronised signal only.
REQ-012 SHALL implement states WAIT_IDLE, IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 WAIT_IDLE -> IDLE when synchronised line is sampled 1; no frame is started from WAIT_IDLE.
REQ-014 IDLE -> START on synchronised line = 0; bit counter cleared to 0 on entry.
REQ-015 Each bit SHALL be decided by 2-of-3 majority of samples at counts M-1, M, M+1, M = CLKS_PER_BIT/2 (integer division), decision taken at count M+1.
REQ-016 START majority = 1 SHALL be treated as a glitch: return to IDLE, no output activity.
REQ-017 DATA SHALL capture 8 bits LSB first, bit n decided CLKS_PER_BIT cycles after bit n-1 decision.
REQ-018 STOP majority = 1 SHALL complete the frame and return to IDLE in the same cycle, permitting back-to-back frames with one stop bit.
REQ-019 STOP majority = 0 SHALL pulse frame_err, discard the byte, go to WAIT_IDLE (break tolerance).
REQ-020 On frame completion rx_valid SHALL assert, with rx_data updated, exactly 1 clk after the stop decision cycle.
REQ-021 rx_valid SHALL deassert the cycle after rx_valid && rx_ready; rx_data SHALL not change while rx_valid=1 except per REQ-023.
REQ-022 Completion while rx_valid=1 and rx_ready=0 SHALL keep old rx_data, drop new byte, pulse overrun_err.
REQ-023 Completion in the same cycle as a handshake SHALL load the new byte with rx_valid staying 1, no overrun_err.
REQ-024 Sample counter width SHALL be $clog2(CLKS_PER_BIT) and SHALL wrap to 0 at CLKS_PER_BIT-1.

Reset
REQ-025 n_reset low SHALL asynchronously force: state WAIT_IDLE, synchroniser flops 1, rx_data 8'h00, rx_valid 0, all error outputs 0, counters 0.
REQ-026 Reset mid-frame SHALL abandon the frame; after release no byte is produced until line seen high, then a full new start bit.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, frame SHALL be 8E1: PARITY state after DATA decides one even-parity bit; mismatch pulses parity_err, discards byte, then STOP still processed for framing (frame_err may also pulse).
REQ-028 Without UART_RX_PARITY_EN, frame SHALL be 8N1, PARITY state absent, parity_err constant 0.

Verification (CLKS_PER_BIT=16)
REQ-029 8N1 byte 0xA5, rx_ready=1 -> rx_valid one-cycle pulse 1 clk after stop decision, rx_data=0xA5, no errors.
REQ-030 Line low 4 clks in IDLE -> no rx_valid, no error pulses, state back to IDLE.
REQ-031 Byte 0x3C with stop bit 0 -> frame_err single pulse, rx_valid stays 0, next byte accepted only after line high.
REQ-032 Bytes 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 held, overrun_err pulse at second completion; raise rx_ready -> rx_valid drops next clk.
REQ-033 UART_RX_PARITY_EN: byte 0x01 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x01.
REQ-034 n_reset pulsed during bit 3 of 0x5A, released with line low -> no output until line high, then 0x7E received correctly.
